frame_timer: RTL and testbench
==============================

# frame_timer

Memory-mapped down-counting timer peripheral on the PicoSoC iomem bus, decoded at 0x08xx_xxxx. Top-level gates `iomem_valid` with the address decode and feeds this block's `iomem_ready` and `iomem_rdata` into the bus muxes. The block's `irq` output drives the CPU's `irq_5` input, giving game firmware a periodic frame/tick interrupt without polling.

## Interface
- `RESET_RELOAD`, default 32'd0: reset value of RELOAD.
- `PRESCALE_W`, default 16: prescaler register width (1..32).
- `clk` in 1: system clock.
- `resetn` in 1: asynchronous, active-low reset.
- `iomem_valid` in 1: request, already gated with the address decode (addr[31:24]==8'h08).
- `iomem_wstrb` in 4: byte write strobes; 0 means read.
- `iomem_addr` in 32: only bits [4:2] are decoded.
- `iomem_wdata` in 32: write data.
- `iomem_ready` out 1: one-cycle acknowledge.
- `iomem_rdata` out 32: read data, valid while `iomem_ready`=1, otherwise 0.
- `irq` out 1: level interrupt; equals `pending & CTRL.irq_en`.

## Operation
- Registers (offset: name):
  - 0x00 CTRL: bit0 `en`, bit1 `auto_reload`, bit2 `irq_en`; other bits read 0.
  - 0x04 RELOAD: 32-bit, read/write.
  - 0x08 COUNT: 32-bit, read/write.
  - 0x0C STATUS: bit0 `pending`; writing 1 clears it, writing 0 has no effect.
  - 0x10 PRESCALE: PRESCALE_W bits, read/write.
  - 0x14–0x1C: unmapped. Reads return 0, writes are ignored, the access is still acknowledged.
- Byte strobes apply per lane to RELOAD, COUNT and PRESCALE. CTRL and STATUS use lane 0 only (`wstrb[0]`).
- Tick: the prescale counter `pcnt` runs while `en`=1. A tick fires when `pcnt`==PRESCALE; `pcnt` then returns to 0. PRESCALE=0 gives a tick every cycle.
- On a tick with `en`=1:
  - If COUNT==0: set `pending`. Then, if `auto_reload`, COUNT<=RELOAD; otherwise `en`<=0 and COUNT stays 0.
  - Otherwise: COUNT<=COUNT-1.
  - Period is therefore (RELOAD+1)·(PRESCALE+1) cycles.
- A CTRL write that takes `en` from 0 to 1 loads COUNT<=RELOAD and clears `pcnt`.
- Counter arithmetic is unsigned modulo 2^32; no underflow past 0.
- Simultaneous events:
  - A COUNT write on a tick cycle: the write wins and the tick decrement is discarded.
  - A STATUS clear on an expiry cycle: the set wins, so `pending` stays 1.
  - A RELOAD write while running: takes effect at the next reload only.
  - A CTRL write with `en`=0: stops the counter immediately; COUNT and `pending` are retained.

## Timing
- Reset values: CTRL=0, RELOAD=RESET_RELOAD, COUNT=0, pending=0, pcnt=0, PRESCALE=0, `iomem_ready`=0, `iomem_rdata`=0, `irq`=0.
- Handshake:
  - `iomem_ready` is a register. It rises on the edge after `iomem_valid`=1 is sampled with `iomem_ready`=0.
  - It stays high for exactly one cycle, then returns to 0 even if `valid` is held. This gives a fixed latency of 1 cycle.
  - Back-to-back requests take 2 cycles each.
- Write commit: a write takes effect on the same edge that raises `iomem_ready`.
- Read data: registered on that edge. COUNT reads return the pre-edge value.
- IRQ latency: `irq` rises on the edge following the expiry tick. It falls on the edge where the STATUS clear commits, or where `irq_en` is written to 0.
- Mid-operation reset: asserting `resetn` low forces all state to reset values asynchronously. Any in-flight bus access is dropped with no ready.

## Configuration
- `FRAME_TIMER_PRESCALER_EN` defined: the PRESCALE register and `pcnt` are present, as described above.
- Not defined:
  - Every cycle with `en`=1 is a tick.
  - PRESCALE reads 0 and writes are ignored (still acknowledged).
  - No prescaler logic is synthesized.
  - Period becomes RELOAD+1 cycles.

## Structure
- Shared package `frame_timer_pkg` holds:
  - register offset constants (`FT_CTRL`, `FT_RELOAD`, `FT_COUNT`, `FT_STATUS`, `FT_PRESCALE`);
  - CTRL bit indices;
  - the base decode byte 8'h08 for top-level decode.
- One sub-module, `frame_timer_prescaler`, holds `pcnt` and the compare, and outputs the 1-cycle `tick`. It is instantiated only under `FRAME_TIMER_PRESCALER_EN`.

## Test plan
- Reset: hold `resetn` low mid-count → all outputs 0. After release, a read of RELOAD returns RESET_RELOAD with `iomem_ready` high for exactly 1 cycle, 1 cycle after `valid`.
- Periodic: RELOAD=4, PRESCALE=2, CTRL=0x7 → `irq` rises every 15 cycles. A STATUS write of 1 drops `irq` on the next edge. COUNT reads sequence 4,3,2,1,0,4.
- One-shot: RELOAD=3, PRESCALE=0, CTRL=0x5 → `irq` after 4 cycles. CTRL reads back 0x4 (`en` cleared), COUNT stays 0.
- Collisions:
  - STATUS clear on the expiry cycle → `pending` stays 1.
  - COUNT=0x10 written on a tick cycle → next read is 0x0F after one further tick, not 0x0F−1.
- Byte strobes: RELOAD=0xAABBCCDD, then write 0x11223344 with wstrb=4'b0010 → RELOAD reads 0xAABB33DD. A write to offset 0x18 is acked and has no effect.
- Macro off: PRESCALE write 5 → reads 0. RELOAD=2 gives `irq` every 3 cycles.

Source files
------------

// File: rtl/frame_timer_pkg.sv
// frame_timer_pkg: register map, CTRL bit positions and byte-lane helper for frame_timer.
package frame_timer_pkg;
  localparam logic [7:0] FT_BASE     = 8'h08;
  localparam logic [4:0] FT_CTRL     = 5'h00;
  localparam logic [4:0] FT_RELOAD   = 5'h04;
  localparam logic [4:0] FT_COUNT    = 5'h08;
  localparam logic [4:0] FT_STATUS   = 5'h0C;
  localparam logic [4:0] FT_PRESCALE = 5'h10;
  localparam int CTRL_EN = 0;
  localparam int CTRL_AR = 1;
  localparam int CTRL_IE = 2;
  function automatic logic [31:0] ft_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                           input logic [3:0] strb);
    return {strb[3] ? new_v[31:24] : old_v[31:24], strb[2] ? new_v[23:16] : old_v[23:16],
            strb[1] ? new_v[15:8] : old_v[15:8], strb[0] ? new_v[7:0] : old_v[7:0]};
  endfunction
endpackage

// File: rtl/frame_timer_prescaler.sv
// frame_timer_prescaler: divides the enabled clock into one-cycle ticks every PRESCALE+1 cycles.
module frame_timer_prescaler #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  i_en,
  input  logic                  i_clr,
  input  logic [PRESCALE_W-1:0] i_prescale,
  output logic                  o_tick
);
  logic [PRESCALE_W-1:0] r_pcnt;
  assign o_tick = i_en & (r_pcnt == i_prescale);
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_pcnt <= '0;
    else if (i_clr || o_tick) r_pcnt <= '0;
    else if (i_en) r_pcnt <= r_pcnt + PRESCALE_W'(1);
  end
endmodule

// File: rtl/frame_timer.sv
// frame_timer: memory-mapped down-counting frame/tick timer with level IRQ on the PicoSoC iomem bus.
// Define FRAME_TIMER_PRESCALER_EN to include the PRESCALE register and tick prescaler.
module frame_timer
  import frame_timer_pkg::*;
#(
  parameter logic [31:0] RESET_RELOAD = 32'd0,
  parameter int          PRESCALE_W   = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic        iomem_ready,
  output logic [31:0] iomem_rdata,
  output logic        irq
);
  logic        r_ready;
  logic [31:0] r_rdata;
  logic [2:0]  r_ctrl;
  logic [31:0] r_reload;
  logic [31:0] r_count;
  logic        r_pending;
  logic        w_acc, w_wr, w_ctrl_wr, w_start, w_stop, w_tick, w_step, w_expire, w_clr;
  logic [4:0]  w_off;
  logic [31:0] w_rd, w_pre32;
  logic        w_unused;
  assign w_acc     = iomem_valid & ~r_ready;
  assign w_wr      = w_acc & |iomem_wstrb;
  assign w_off     = {iomem_addr[4:2], 2'b00};
  assign w_ctrl_wr = w_wr & (w_off == FT_CTRL) & iomem_wstrb[0];
  assign w_clr     = w_wr & (w_off == FT_STATUS) & iomem_wstrb[0] & iomem_wdata[0];
  assign w_start   = w_ctrl_wr & iomem_wdata[CTRL_EN] & ~r_ctrl[CTRL_EN];
  assign w_stop    = w_ctrl_wr & ~iomem_wdata[CTRL_EN];
  // A stopping CTRL write takes priority over a tick landing on the same edge.
  assign w_step    = w_tick & ~w_stop;
  assign w_expire  = w_step & (r_count == '0);
  assign w_unused  = ^{iomem_addr[31:24] == FT_BASE, iomem_addr[23:5], iomem_addr[1:0]};
`ifdef FRAME_TIMER_PRESCALER_EN
  logic [PRESCALE_W-1:0] r_prescale;
  assign w_pre32 = 32'(r_prescale);
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_prescale <= '0;
    else if (w_wr && w_off == FT_PRESCALE)
      r_prescale <= PRESCALE_W'(ft_merge(w_pre32, iomem_wdata, iomem_wstrb));
  end
  frame_timer_prescaler #(.PRESCALE_W(PRESCALE_W)) u_pre (
    .clk       (clk),
    .resetn    (resetn),
    .i_en      (r_ctrl[CTRL_EN]),
    .i_clr     (w_start),
    .i_prescale(r_prescale),
    .o_tick    (w_tick)
  );
`else
  logic w_unused_pw;
  assign w_unused_pw = PRESCALE_W > 0;
  assign w_pre32     = '0;
  assign w_tick      = r_ctrl[CTRL_EN];
`endif
  assign w_rd = w_off == FT_CTRL     ? {29'd0, r_ctrl} :
                w_off == FT_RELOAD   ? r_reload :
                w_off == FT_COUNT    ? r_count :
                w_off == FT_STATUS   ? {31'd0, r_pending} :
                w_off == FT_PRESCALE ? w_pre32 : '0;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ready   <= 1'b0;
      r_rdata   <= '0;
      r_ctrl    <= '0;
      r_reload  <= RESET_RELOAD;
      r_count   <= '0;
      r_pending <= 1'b0;
    end else begin
      r_ready <= w_acc;
      r_rdata <= w_acc ? w_rd : '0;
      if (w_expire) r_pending <= 1'b1;
      else if (w_clr) r_pending <= 1'b0;
      if (w_expire && !r_ctrl[CTRL_AR]) r_ctrl[CTRL_EN] <= 1'b0;
      if (w_ctrl_wr) r_ctrl <= iomem_wdata[2:0];
      if (w_wr && w_off == FT_RELOAD) r_reload <= ft_merge(r_reload, iomem_wdata, iomem_wstrb);
      if (w_wr && w_off == FT_COUNT) r_count <= ft_merge(r_count, iomem_wdata, iomem_wstrb);
      else if (w_start) r_count <= r_reload;
      else if (w_expire) r_count <= r_ctrl[CTRL_AR] ? r_reload : r_count;
      else if (w_step) r_count <= r_count - 32'd1;
    end
  end
  assign iomem_ready = r_ready;
  assign iomem_rdata = r_rdata;
  assign irq         = r_pending & r_ctrl[CTRL_IE];
endmodule

// File: tb/tb_frame_timer.sv
// tb_frame_timer: directed self-checking bench for frame_timer (either FRAME_TIMER_PRESCALER_EN setting).
module tb_frame_timer;
  localparam logic [31:0] A_CTRL   = 32'h0800_0000;
  localparam logic [31:0] A_RELOAD = 32'h0800_0004;
  localparam logic [31:0] A_COUNT  = 32'h0800_0008;
  localparam logic [31:0] A_STATUS = 32'h0800_000C;
  localparam logic [31:0] A_PRE    = 32'h0800_0010;
  localparam logic [31:0] A_UNM    = 32'h0800_0018;
  localparam logic [31:0] RST_RLD  = 32'h1234_5678;
  logic        clk = 1'b0;
  logic        resetn, valid;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata, q;
  logic        ready, irq;
  logic [31:0] rdata;
  int          tests = 0, fails = 0, cyc = 0, t_acc = 0, t_en = 0;
  frame_timer #(.RESET_RELOAD(RST_RLD), .PRESCALE_W(16)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .iomem_valid(valid),
    .iomem_wstrb(wstrb),
    .iomem_addr (addr),
    .iomem_wdata(wdata),
    .iomem_ready(ready),
    .iomem_rdata(rdata),
    .irq        (irq)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    valid = 1'b1; addr = a; wdata = d; wstrb = s;
    @(posedge clk); #1;
    q = rdata; t_acc = cyc;
    chk("ready_ack", {31'd0, ready}, 32'd1);
    valid = 1'b0; wstrb = 4'd0;
  endtask
  task automatic acc(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    @(negedge clk);
    while (ready && n < 4) begin @(negedge clk); n++; end
    issue(a, d, s);
  endtask
  task automatic issue_at(input int target, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    do @(negedge clk); while (cyc < target - 1);
    issue(a, d, s);
  endtask
  task automatic at_cyc(input int target);
    do @(negedge clk); while (cyc < target);
  endtask
  task automatic wait_irq(input int lim);
    int n = 0;
    while (!irq && n < lim) begin @(negedge clk); n++; end
    chk("irq_timeout", {31'd0, irq}, 32'd1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    resetn = 1'b0; valid = 1'b0; wstrb = 4'd0; addr = '0; wdata = '0;
    #12;
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk); resetn = 1'b1;
    // first access: ready exactly one cycle, one cycle after valid
    @(negedge clk);
    chk("pre_ready", {31'd0, ready}, 32'd0);
    issue(A_RELOAD, 32'd0, 4'd0);
    chk("reload_rst", q, RST_RLD);
    @(posedge clk); #1;
    chk("ready_1cyc", {31'd0, ready}, 32'd0);
    chk("rdata_idle", rdata, 32'd0);
    acc(A_CTRL, 0, 0);   chk("ctrl_rst", q, 32'd0);
    acc(A_COUNT, 0, 0);  chk("count_rst", q, 32'd0);
    acc(A_STATUS, 0, 0); chk("status_rst", q, 32'd0);
    // byte strobes and unmapped space
    acc(A_RELOAD, 32'hAABBCCDD, 4'hF);
    acc(A_RELOAD, 32'h11223344, 4'b0010);
    acc(A_RELOAD, 0, 0); chk("reload_lane1", q, 32'hAABB33DD);
    acc(A_UNM, 32'hFFFFFFFF, 4'hF);
    acc(A_UNM, 0, 0);    chk("unmapped_rd", q, 32'd0);
    acc(A_RELOAD, 0, 0); chk("unmapped_wr_reload", q, 32'hAABB33DD);
    acc(A_CTRL, 0, 0);   chk("unmapped_wr_ctrl", q, 32'd0);
    // COUNT write on a tick cycle beats the decrement
    acc(A_PRE, 32'd0, 4'hF);
    acc(A_RELOAD, 32'h100, 4'hF);
    acc(A_CTRL, 32'd1, 4'hF);
    acc(A_COUNT, 32'h10, 4'hF);
    acc(A_COUNT, 0, 0);  chk("count_wr_wins", q, 32'h0F);
    acc(A_CTRL, 32'd0, 4'hF);
    // one-shot
    acc(A_RELOAD, 32'd3, 4'hF);
    acc(A_CTRL, 32'd5, 4'hF); t_en = t_acc;
    wait_irq(20);
    chk("oneshot_lat", 32'(cyc - t_en), 32'd4);
    acc(A_CTRL, 0, 0);   chk("oneshot_ctrl", q, 32'd4);
    acc(A_COUNT, 0, 0);  chk("oneshot_count", q, 32'd0);
    repeat (5) @(negedge clk);
    acc(A_COUNT, 0, 0);  chk("oneshot_hold", q, 32'd0);
    acc(A_STATUS, 32'd1, 4'hF);
    chk("oneshot_clr_irq", {31'd0, irq}, 32'd0);
    // STATUS clear landing on an expiry edge: set wins
    acc(A_RELOAD, 32'd9, 4'hF);
    acc(A_CTRL, 32'd7, 4'hF); t_en = t_acc;
    wait_irq(30);
    chk("period10", 32'(cyc - t_en), 32'd10);
    issue_at(t_en + 20, A_STATUS, 32'd1, 4'hF);
    chk("set_wins_irq", {31'd0, irq}, 32'd1);
    acc(A_STATUS, 0, 0); chk("set_wins_status", q, 32'd1);
    acc(A_CTRL, 32'd3, 4'hF);
    chk("irq_en_off", {31'd0, irq}, 32'd0);
    acc(A_STATUS, 32'd1, 4'hF);
    acc(A_CTRL, 32'd0, 4'hF);
`ifdef FRAME_TIMER_PRESCALER_EN
    acc(A_PRE, 32'd2, 4'hF);
    acc(A_PRE, 0, 0);    chk("prescale_rd", q, 32'd2);
    acc(A_RELOAD, 32'd4, 4'hF);
    acc(A_CTRL, 32'd7, 4'hF); t_en = t_acc;
    issue_at(t_en + 2, A_COUNT, 0, 0);  chk("seq4", q, 32'd4);
    issue_at(t_en + 5, A_COUNT, 0, 0);  chk("seq3", q, 32'd3);
    issue_at(t_en + 8, A_COUNT, 0, 0);  chk("seq2", q, 32'd2);
    issue_at(t_en + 11, A_COUNT, 0, 0); chk("seq1", q, 32'd1);
    issue_at(t_en + 14, A_COUNT, 0, 0); chk("seq0", q, 32'd0);
    chk("irq_before15", {31'd0, irq}, 32'd0);
    at_cyc(t_en + 15);
    chk("irq_at15", {31'd0, irq}, 32'd1);
    issue_at(t_en + 17, A_COUNT, 0, 0); chk("seq_reload", q, 32'd4);
    acc(A_STATUS, 32'd1, 4'hF);
    chk("clr_irq", {31'd0, irq}, 32'd0);
    wait_irq(40);
    chk("period15", 32'(cyc - t_en), 32'd30);
    acc(A_CTRL, 32'd0, 4'hF);
    acc(A_STATUS, 32'd1, 4'hF);
    acc(A_PRE, 32'd0, 4'hF);
`else
    acc(A_PRE, 32'd5, 4'hF);
    acc(A_PRE, 0, 0);    chk("prescale_off", q, 32'd0);
    acc(A_RELOAD, 32'd2, 4'hF);
    acc(A_CTRL, 32'd7, 4'hF); t_en = t_acc;
    wait_irq(10);
    chk("period3_a", 32'(cyc - t_en), 32'd3);
    acc(A_STATUS, 32'd1, 4'hF);
    chk("clr_irq", {31'd0, irq}, 32'd0);
    wait_irq(10);
    chk("period3_b", 32'(cyc - t_en), 32'd6);
    acc(A_CTRL, 32'd0, 4'hF);
    acc(A_STATUS, 32'd1, 4'hF);
`endif
    // asynchronous reset while counting, with an access in flight
    acc(A_RELOAD, 32'd9, 4'hF);
    acc(A_CTRL, 32'd7, 4'hF);
    wait_irq(30);
    @(negedge clk);
    valid = 1'b1; addr = A_RELOAD; wstrb = 4'd0;
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, ready}, 32'd0);
    chk("mid_rst_rdata", rdata, 32'd0);
    chk("mid_rst_irq", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
    chk("mid_rst_drop", {31'd0, ready}, 32'd0);
    valid = 1'b0;
    @(negedge clk); resetn = 1'b1;
    acc(A_CTRL, 0, 0);   chk("post_rst_ctrl", q, 32'd0);
    acc(A_RELOAD, 0, 0); chk("post_rst_reload", q, RST_RLD);
    acc(A_COUNT, 0, 0);  chk("post_rst_count", q, 32'd0);
    acc(A_STATUS, 0, 0); chk("post_rst_status", q, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
